// File: rtl/ajustador_ancho_pkg.sv
// Shared mode encodings and counter sizing for the sample-width adjuster.
package ajustador_ancho_pkg;

    localparam logic [1:0] MODO_SEXT = 2'b00;
    localparam logic [1:0] MODO_ZEXT = 2'b01;
    localparam logic [1:0] MODO_SAT  = 2'b10;
    localparam logic [1:0] MODO_RSAT = 2'b11;

    localparam int SAT_CNT_W = 16;
    localparam logic [SAT_CNT_W-1:0] SAT_CNT_MAX = '1;

    function automatic logic es_saturante(input logic [1:0] modo);
        return (modo == MODO_SAT) || (modo == MODO_RSAT);
    endfunction

endpackage

// File: rtl/ajustador_ancho_saturador.sv
// Combinational resize of a signed IN_W-bit value to N_OUT bits: extend, wrap or clamp by mode.
module ajustador_ancho_saturador
    import ajustador_ancho_pkg::*;
#(
    parameter int IN_W  = 26,
    parameter int N_OUT = 50
) (
    input  logic [IN_W-1:0]  i_valor,
    input  logic [1:0]       i_modo,
    output logic [N_OUT-1:0] o_valor,
    output logic             o_sat
);

    generate
        if (N_OUT >= IN_W) begin : g_ext
            always_comb begin
                o_sat = 1'b0;
                if (i_modo == MODO_ZEXT) begin
                    o_valor = N_OUT'(i_valor);
                end else begin
                    o_valor = N_OUT'(signed'(i_valor));
                end
            end
        end else begin : g_clamp
            // Fits only if every bit from the new sign position upwards agrees.
            logic w_ovf;
            assign w_ovf = !(&i_valor[IN_W-1:N_OUT-1]) && (|i_valor[IN_W-1:N_OUT-1]);

            always_comb begin
                o_valor = i_valor[N_OUT-1:0];
                o_sat   = 1'b0;
                if (es_saturante(i_modo) && w_ovf) begin
                    o_sat   = 1'b1;
                    o_valor = i_valor[IN_W-1] ? {1'b1, {(N_OUT-1){1'b0}}}
                                              : {1'b0, {(N_OUT-1){1'b1}}};
                end
            end
        end
    endgenerate

endmodule

// File: rtl/ajustador_ancho.sv
// Two-stage valid/ready width adjuster: shift/round, then resize with saturation counting.
module ajustador_ancho
    import ajustador_ancho_pkg::*;
#(
    parameter int N_IN  = 25,
    parameter int N_OUT = 50,
    parameter int SHIFT = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [N_IN-1:0]      in_data,
    input  logic [1:0]           modo,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [N_OUT-1:0]     out_data,
    output logic                 out_sat,
    output logic [SAT_CNT_W-1:0] sat_count,
    input  logic                 clr_count
);

    localparam int RND_POS = (SHIFT > 0) ? SHIFT - 1 : 0;
    localparam logic [N_IN:0] RND = (SHIFT > 0) ? ((N_IN + 1)'(1) << RND_POS) : '0;

    logic                 r_alive;
    logic                 r_s1_valid;
    logic [N_IN:0]        r_s1_data;
    logic [1:0]           r_s1_modo;
    logic                 r_out_valid;
    logic [N_OUT-1:0]     r_out_data;
    logic                 r_out_sat;
    logic [SAT_CNT_W-1:0] r_sat_count;

    logic                 w_s2_load;
    logic                 w_in_ready;
    logic                 w_out_fire;
    logic signed [N_IN:0] w_ext;
    logic signed [N_IN:0] w_sum;
    logic signed [N_IN:0] w_shift;
    logic [N_OUT-1:0]     w_sat_valor;
    logic                 w_sat_flag;

    assign w_s2_load  = !r_out_valid || out_ready;
    assign w_in_ready = r_alive && (!r_s1_valid || w_s2_load);
    assign w_out_fire = r_out_valid && out_ready;

    // One guard bit keeps the rounding addend from overflowing.
    always_comb begin
        w_ext = (modo == MODO_ZEXT) ? {1'b0, in_data} : {in_data[N_IN-1], in_data};
        w_sum = w_ext;
        if (modo == MODO_RSAT) begin
            w_sum = w_ext + RND;
        end
        w_shift = w_sum >>> SHIFT;
    end

    ajustador_ancho_saturador #(
        .IN_W  (N_IN + 1),
        .N_OUT (N_OUT)
    ) u_saturador (
        .i_valor (r_s1_data),
        .i_modo  (r_s1_modo),
        .o_valor (w_sat_valor),
        .o_sat   (w_sat_flag)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_alive     <= 1'b0;
            r_s1_valid  <= 1'b0;
            r_s1_data   <= '0;
            r_s1_modo   <= MODO_SEXT;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_sat   <= 1'b0;
            r_sat_count <= '0;
        end else begin
            r_alive <= 1'b1;
            if (w_in_ready) begin
                r_s1_valid <= in_valid;
                if (in_valid) begin
                    r_s1_data <= w_shift;
                    r_s1_modo <= modo;
                end
            end
            if (w_s2_load) begin
                r_out_valid <= r_s1_valid;
                if (r_s1_valid) begin
                    r_out_data <= w_sat_valor;
                    r_out_sat  <= w_sat_flag;
                end
            end
            if (clr_count) begin
                r_sat_count <= '0;
            end else if (w_out_fire && r_out_sat && (r_sat_count != SAT_CNT_MAX)) begin
                r_sat_count <= r_sat_count + SAT_CNT_W'(1);
            end
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_sat   = r_out_sat;
    assign sat_count = r_sat_count;

endmodule

// File: tb/tb_ajustador_ancho.sv
// Directed checks of ajustador_ancho in a widening (25->50) and a narrowing (25->16, shift 4) build.
module tb_ajustador_ancho;
    import ajustador_ancho_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_sat, a_clr;
    logic [24:0] a_in_data;
    logic [1:0]  a_modo;
    logic [49:0] a_out_data;
    logic [15:0] a_cnt;

    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_sat, b_clr;
    logic [24:0] b_in_data;
    logic [1:0]  b_modo;
    logic [15:0] b_out_data;
    logic [15:0] b_cnt;

    int n_pass  = 0;
    int n_total = 0;

    ajustador_ancho #(.N_IN(25), .N_OUT(50), .SHIFT(0)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data), .modo(a_modo),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
        .out_sat(a_out_sat), .sat_count(a_cnt), .clr_count(a_clr)
    );

    ajustador_ancho #(.N_IN(25), .N_OUT(16), .SHIFT(4)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data), .modo(b_modo),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .out_sat(b_out_sat), .sat_count(b_cnt), .clr_count(b_clr)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
            $display("ok   %s = 0x%0h", tag, obs);
        end else begin
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge; returns at the falling edge after acceptance.
    task automatic push_b(input logic [24:0] d, input logic [1:0] m);
        int waitc = 0;
        b_in_valid = 1'b1;
        b_in_data  = d;
        b_modo     = m;
        while (!b_in_ready && waitc < 50) begin
            @(negedge clk);
            waitc++;
        end
        if (!b_in_ready) chk("push_b in_ready timeout", 64'(b_in_ready), 64'(1));
        @(posedge clk);
        @(negedge clk);
        b_in_valid = 1'b0;
    endtask

    task automatic run_b(input string tag, input logic [24:0] d, input logic [1:0] m,
                         input logic [15:0] exp_d, input logic exp_s);
        push_b(d, m);
        chk({tag, " valid@1"}, 64'(b_out_valid), 64'(0));
        @(negedge clk);
        chk({tag, " valid@2"}, 64'(b_out_valid), 64'(1));
        chk({tag, " data"}, 64'(b_out_data), 64'(exp_d));
        chk({tag, " sat"}, 64'(b_out_sat), 64'(exp_s));
        @(negedge clk);
    endtask

    task automatic run_a(input string tag, input logic [24:0] d, input logic [1:0] m,
                         input logic [49:0] exp_d);
        chk({tag, " in_ready"}, 64'(a_in_ready), 64'(1));
        a_in_valid = 1'b1;
        a_in_data  = d;
        a_modo     = m;
        @(posedge clk);
        @(negedge clk);
        a_in_valid = 1'b0;
        chk({tag, " valid@1"}, 64'(a_out_valid), 64'(0));
        @(negedge clk);
        chk({tag, " valid@2"}, 64'(a_out_valid), 64'(1));
        chk({tag, " data"}, 64'(a_out_data), 64'(exp_d));
        chk({tag, " sat"}, 64'(a_out_sat), 64'(0));
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        a_in_valid = 1'b0; a_in_data = '0; a_modo = MODO_SEXT; a_out_ready = 1'b1; a_clr = 1'b0;
        b_in_valid = 1'b0; b_in_data = '0; b_modo = MODO_SEXT; b_out_ready = 1'b1; b_clr = 1'b0;

        repeat (2) @(negedge clk);
        chk("rst a in_ready", 64'(a_in_ready), 64'(0));
        chk("rst a out_valid", 64'(a_out_valid), 64'(0));
        chk("rst b out_valid", 64'(b_out_valid), 64'(0));
        chk("rst b out_data", 64'(b_out_data), 64'(0));
        chk("rst b sat_count", 64'(b_cnt), 64'(0));
        rst_n = 1'b1;
        @(negedge clk);
        chk("post-rst a in_ready", 64'(a_in_ready), 64'(1));
        chk("post-rst b in_ready", 64'(b_in_ready), 64'(1));

        // Widening 25 -> 50
        run_a("a sext", 25'h1000000, MODO_SEXT, 50'h3FFFFFF000000);
        run_a("a zext", 25'h1000000, MODO_ZEXT, 50'h00000001000000);

        // Narrowing 25 -> 16 with shift 4
        run_b("b sat pos", 25'h0FFFFFF, MODO_SAT, 16'h7FFF, 1'b1);
        run_b("b sat neg", 25'h1000000, MODO_SAT, 16'h8000, 1'b1);
        chk("b sat_count 2", 64'(b_cnt), 64'(2));
        run_b("b trunc 24", 25'h0000018, MODO_SAT, 16'h0001, 1'b0);
        run_b("b round 24", 25'h0000018, MODO_RSAT, 16'h0002, 1'b0);
        run_b("b round -24", 25'h1FFFFE8, MODO_RSAT, 16'hFFFF, 1'b0);
        run_b("b wrap sext", 25'h0FFFFFF, MODO_SEXT, 16'hFFFF, 1'b0);
        run_b("b wrap zext", 25'h1000000, MODO_ZEXT, 16'h0000, 1'b0);
        chk("b sat_count still 2", 64'(b_cnt), 64'(2));

        // Backpressure: three pushes with the consumer stalled
        b_out_ready = 1'b0;
        b_in_valid = 1'b1; b_in_data = 25'h10; b_modo = MODO_SAT;
        chk("bp ready s0", 64'(b_in_ready), 64'(1));
        @(negedge clk);
        b_in_data = 25'h20;
        chk("bp ready s1", 64'(b_in_ready), 64'(1));
        @(negedge clk);
        b_in_data = 25'h30;
        chk("bp full in_ready", 64'(b_in_ready), 64'(0));
        chk("bp out_valid", 64'(b_out_valid), 64'(1));
        chk("bp head data", 64'(b_out_data), 64'(1));
        repeat (2) @(negedge clk);
        chk("bp stall in_ready", 64'(b_in_ready), 64'(0));
        chk("bp stall data", 64'(b_out_data), 64'(1));
        chk("bp stall valid", 64'(b_out_valid), 64'(1));
        b_out_ready = 1'b1;
        #1;
        chk("bp release in_ready", 64'(b_in_ready), 64'(1));
        @(negedge clk);
        b_in_valid = 1'b0;
        chk("bp out 2", 64'(b_out_data), 64'(2));
        @(negedge clk);
        chk("bp out 3 valid", 64'(b_out_valid), 64'(1));
        chk("bp out 3", 64'(b_out_data), 64'(3));
        @(negedge clk);
        chk("bp drained", 64'(b_out_valid), 64'(0));

        // Asynchronous reset with two samples in flight
        b_in_valid = 1'b1; b_in_data = 25'h0FFFFFF; b_modo = MODO_SAT;
        @(negedge clk);
        b_in_data = 25'h1000000;
        @(negedge clk);
        b_in_valid = 1'b0;
        chk("mid in flight", 64'(b_out_valid), 64'(1));
        rst_n = 1'b0;
        #1;
        chk("async rst out_valid", 64'(b_out_valid), 64'(0));
        chk("async rst sat_count", 64'(b_cnt), 64'(0));
        chk("async rst out_sat", 64'(b_out_sat), 64'(0));
        chk("async rst in_ready", 64'(b_in_ready), 64'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rerst in_ready", 64'(b_in_ready), 64'(1));
        chk("rerst no stale", 64'(b_out_valid), 64'(0));
        run_b("b after rst", 25'h0000018, MODO_RSAT, 16'h0002, 1'b0);
        chk("after rst sat_count", 64'(b_cnt), 64'(0));

        // Saturation counter
        b_in_valid = 1'b1; b_in_data = 25'h0FFFFFF; b_modo = MODO_SAT;
        repeat (100) @(negedge clk);
        b_in_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("cnt 100", 64'(b_cnt), 64'(100));
        b_in_valid = 1'b1;
        repeat (65437) @(negedge clk);
        b_in_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("cnt 65537 held", 64'(b_cnt), 64'(16'hFFFF));
        run_b("b sat at max", 25'h0FFFFFF, MODO_SAT, 16'h7FFF, 1'b1);
        chk("cnt stays max", 64'(b_cnt), 64'(16'hFFFF));
        push_b(25'h0FFFFFF, MODO_SAT);
        @(negedge clk);
        chk("clr with transfer valid", 64'(b_out_valid), 64'(1));
        b_clr = 1'b1;
        @(negedge clk);
        b_clr = 1'b0;
        chk("clr priority", 64'(b_cnt), 64'(0));
        run_b("b after clr", 25'h1000000, MODO_SAT, 16'h8000, 1'b1);
        chk("cnt after clr", 64'(b_cnt), 64'(1));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
